// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction port and fills the
// IF/ID pipeline register; stops on the end-of-program word or a bad fetch address.
module if_stage_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h0000_2000,
    parameter logic [31:0] EOF_WORD   = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic [31:0] instr,
    output logic [31:0] inst_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
    output logic        halted,
    output logic        fetch_fault
);
    typedef enum logic [1:0] {S_RUN = 2'd0, S_HALTED = 2'd1, S_FAULT = 2'd2} state_t;
    typedef enum logic [1:0] {A_HOLD = 2'd0, A_LOAD = 2'd1, A_BUBBLE = 2'd2} ifid_act_t;

    localparam logic [31:0] LAST_ADDR = ADDR_LIMIT - 32'd4;

    function automatic logic target_legal(input logic [31:0] t);
        return (t[1:0] == 2'b00) && (t <= LAST_ADDR);
    endfunction

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_ipc;
    logic [31:0] r_ipc4;
    logic        r_valid;
    logic        r_halted;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic        w_target_ok;
    logic        w_is_eof;
    logic        w_at_end;
    ifid_act_t   w_act;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_target_ok = target_legal(redirect_pc);
    assign w_is_eof    = (instr == EOF_WORD);
    assign w_at_end    = (w_pc_plus4 > LAST_ADDR);

    assign inst_addr      = r_pc;
    assign if_id_instr    = r_instr;
    assign if_id_pc       = r_ipc;
    assign if_id_pc_plus4 = r_ipc4;
    assign if_id_valid    = r_valid;
    assign halted         = r_halted;
    assign fetch_fault    = r_fault;

    // Decide whether IF/ID holds, loads the fetched word, or takes a bubble this cycle.
    always_comb begin
        w_act = A_BUBBLE;
        case (r_state)
            S_RUN: begin
                if (redirect && !w_target_ok) begin
                    w_act = A_BUBBLE;
                end else if (flush) begin
                    w_act = A_BUBBLE;
                end else if (stall) begin
                    w_act = A_HOLD;
                end else if (!redirect && (w_is_eof || w_at_end)) begin
                    w_act = A_BUBBLE;
                end else begin
                    w_act = A_LOAD;
                end
            end
            S_HALTED: begin
                if (flush) begin
                    w_act = A_BUBBLE;
                end else if (stall) begin
                    w_act = A_HOLD;
                end else begin
                    w_act = A_BUBBLE;
                end
            end
            default: w_act = A_BUBBLE;
        endcase
    end

    // Fetch state machine, PC and the IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
            r_instr  <= 32'd0;
            r_ipc    <= 32'd0;
            r_ipc4   <= 32'd0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (redirect && !w_target_ok) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (redirect) begin
                        r_pc <= redirect_pc;
                    end else if (stall) begin
                        r_pc <= r_pc;
                    end else if (w_is_eof) begin
                        r_state  <= S_HALTED;
                        r_halted <= 1'b1;
                    end else if (w_at_end) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else begin
                        r_pc <= w_pc_plus4;
                    end
                end
                S_HALTED: begin
                    // A redirect out of HALTED recovers from an EOF fetched on a wrong path.
                    if (redirect && w_target_ok) begin
                        r_state  <= S_RUN;
                        r_halted <= 1'b0;
                        r_pc     <= redirect_pc;
                    end else if (redirect) begin
                        r_state  <= S_FAULT;
                        r_halted <= 1'b0;
                        r_fault  <= 1'b1;
                    end else begin
                        r_pc <= r_pc;
                    end
                end
                S_FAULT: begin
                    r_fault <= 1'b1;
                end
                default: begin
                    r_state  <= S_FAULT;
                    r_halted <= 1'b0;
                    r_fault  <= 1'b1;
                end
            endcase

            case (w_act)
                A_LOAD: begin
                    r_instr <= instr;
                    r_ipc   <= r_pc;
                    r_ipc4  <= w_pc_plus4;
                    r_valid <= 1'b1;
                end
                A_BUBBLE: begin
                    r_instr <= 32'd0;
                    r_ipc   <= 32'd0;
                    r_ipc4  <= 32'd0;
                    r_valid <= 1'b0;
                end
                default: begin
                    r_instr <= r_instr;
                    r_ipc   <= r_ipc;
                    r_ipc4  <= r_ipc4;
                    r_valid <= r_valid;
                end
            endcase
        end
    end

endmodule
